seg7_scan_driver: RTL and testbench

Time-multiplexed eight-digit seven-segment driver that sits directly downstream of the memory-mapped output-device register file. It consumes the 32-bit word on the output device's read-data port and shows it as eight hex digits on a common-anode board display. The word is captured once per scan frame, so a CPU store never tears a frame. Digits are scanned at a programmable rate.

---
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 tb/tb_seg7_scan_driver.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver; DataIn/DpMask are snapshotted once per frame.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
`timescale 1ns/1ps
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataIn,
    input  logic [7:0]  DpMask,
    input  logic        Blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        Frame
);

    localparam int unsigned   PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pcnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_snap;
    logic [7:0]    r_snapdp;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic          w_tick;
    logic          w_wrap;
    logic          w_an_off;
    logic [3:0]    w_nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        unique case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
        endcase
    endfunction

    assign w_tick   = (r_pcnt == PCNT_MAX);
    assign w_wrap   = w_tick && (r_idx == 3'd7);
    assign w_nibble = r_snap[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZB_EN
    // Bit i set when digit i carries a significant nibble; digit 0 always does.
    logic [7:0] w_digit_on;
    assign w_digit_on[0] = 1'b1;
    for (genvar gi = 1; gi < 8; gi++) begin : g_lzb
        assign w_digit_on[gi] = |r_snap[31:4*gi];
    end
    assign w_an_off = Blank | ~w_digit_on[r_idx];
`else
    assign w_an_off = Blank;
`endif

    // NOTE: all state here updates with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt   <= '0;
            r_idx    <= 3'd0;
            r_snap   <= 32'd0;
            r_snapdp <= 8'd0;
            r_an     <= 8'hFF;
            r_seg    <= 7'h7F;
            r_dp     <= 1'b1;
            r_frame  <= 1'b0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
            end
            // Capture only at the frame wrap so a mid-frame store never tears the display.
            if (w_wrap) begin
                r_snap   <= DataIn;
                r_snapdp <= DpMask;
            end
            r_frame <= w_wrap;
            r_an    <= w_an_off ? 8'hFF : ~(8'h01 << r_idx);
            r_seg   <= hex_to_seg(w_nibble);
            r_dp    <= ~r_snapdp[r_idx];
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign Frame = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: CLK_DIV=4 and CLK_DIV=1 instances against a frame-arithmetic model.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] DataIn = 32'd0;
    logic [7:0]  DpMask = 8'd0;
    logic        Blank = 1'b0;

    logic [7:0]  an_d    [2];
    logic [6:0]  seg_d   [2];
    logic        dp_d    [2];
    logic        frame_d [2];

    int vectors = 0;
    int miscompares = 0;
    bit sb_en = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .DataIn(DataIn), .DpMask(DpMask), .Blank(Blank),
        .an(an_d[0]), .seg(seg_d[0]), .dp(dp_d[0]), .Frame(frame_d[0])
    );

    seg7_scan_driver #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .DataIn(DataIn), .DpMask(DpMask), .Blank(Blank),
        .an(an_d[1]), .seg(seg_d[1]), .dp(dp_d[1]), .Frame(frame_d[1])
    );

    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference: digit on display after k edges since reset is (k / div) mod 8.
    function automatic logic [7:0] ref_anode(logic [31:0] s, int unsigned k, int unsigned d, logic b);
        int unsigned i;
        logic [7:0]  v;
        bit          off;
        i   = (k / d) % 8;
        v   = 8'hFF;
        off = b;
`ifdef SEG7_LZB_EN
        if (i != 0 && (s >> (4 * i)) == 32'd0) off = 1'b1;
`endif
        if (!off) v[i[2:0]] = 1'b0;
        return v;
    endfunction

    function automatic logic [6:0] ref_seg(logic [31:0] s, int unsigned k, int unsigned d);
        int unsigned i;
        logic [31:0] t;
        i = (k / d) % 8;
        t = s >> (4 * i);
        return HEX7[t[3:0]];
    endfunction

    function automatic logic ref_dp(logic [7:0] m, int unsigned k, int unsigned d);
        int unsigned i;
        i = (k / d) % 8;
        return ~m[i[2:0]];
    endfunction

    for (genvar j = 0; j < 2; j++) begin : g_model
        localparam int unsigned D = (j == 0) ? 4 : 1;
        int unsigned k;
        logic [31:0] s;
        logic [7:0]  sdp;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_frame;
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                k <= 0; s <= 32'd0; sdp <= 8'd0;
                e_an <= 8'hFF; e_seg <= 7'h7F; e_dp <= 1'b1; e_frame <= 1'b0;
            end else begin
                e_an    <= ref_anode(s, k, D, Blank);
                e_seg   <= ref_seg(s, k, D);
                e_dp    <= ref_dp(sdp, k, D);
                e_frame <= ((k % (8 * D)) == 8 * D - 1);
                if ((k % (8 * D)) == 8 * D - 1) begin
                    s   <= DataIn;
                    sdp <= DpMask;
                end
                k <= k + 1;
            end
        end
    end

    // Every-cycle scoreboard against the model for both instances.
    initial forever begin
        @(negedge clk);
        if (sb_en && !rst) begin
            vectors++;
            if ({an_d[0], seg_d[0], dp_d[0], frame_d[0]} !==
                {g_model[0].e_an, g_model[0].e_seg, g_model[0].e_dp, g_model[0].e_frame}) begin
                miscompares++;
                $display("FAIL model_div4 t=%0t got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b",
                         $time, an_d[0], seg_d[0], dp_d[0], frame_d[0],
                         g_model[0].e_an, g_model[0].e_seg, g_model[0].e_dp, g_model[0].e_frame);
            end
            vectors++;
            if ({an_d[1], seg_d[1], dp_d[1], frame_d[1]} !==
                {g_model[1].e_an, g_model[1].e_seg, g_model[1].e_dp, g_model[1].e_frame}) begin
                miscompares++;
                $display("FAIL model_div1 t=%0t got an=%h seg=%h dp=%b frame=%b want an=%h seg=%h dp=%b frame=%b",
                         $time, an_d[1], seg_d[1], dp_d[1], frame_d[1],
                         g_model[1].e_an, g_model[1].e_seg, g_model[1].e_dp, g_model[1].e_frame);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    task automatic test_reset();
        int n;
        bit seen;
        rst = 1'b1; Blank = 1'b0; DpMask = 8'd0; DataIn = 32'h12345678;
        repeat (3) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if ({an_d[j], seg_d[j], dp_d[j], frame_d[j]} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_values dut%0d got an=%h seg=%h dp=%b frame=%b want an=ff seg=7f dp=1 frame=0",
                         j, an_d[j], seg_d[j], dp_d[j], frame_d[j]);
            end
        end
        rst = 1'b0;
        sb_en = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            vectors++;
            if (seg_d[0] !== 7'h40) begin
                miscompares++;
                $display("FAIL first_frame_seg cycle %0d got %h want 40", n, seg_d[0]);
            end
            seen = frame_d[0];
        end
        vectors++;
        if (!seen || n != 32) begin
            miscompares++;
            $display("FAIL frame_latency got %0d cycles (seen=%b) want 32", n, seen);
        end
        @(negedge clk);
        vectors++;
        if (an_d[0] !== 8'hFE || seg_d[0] !== 7'h00) begin
            miscompares++;
            $display("FAIL second_frame_digit0 got an=%h seg=%h want an=fe seg=00", an_d[0], seg_d[0]);
        end
        repeat (28) @(negedge clk);
        vectors++;
        if (an_d[0] !== 8'h7F || seg_d[0] !== 7'h79) begin
            miscompares++;
            $display("FAIL second_frame_digit7 got an=%h seg=%h want an=7f seg=79", an_d[0], seg_d[0]);
        end
    endtask

    task automatic test_scan_order();
        logic [7:0] prev0, prev1;
        int ch0, ch1, fr0, fr1, bad_rot, bad_gap, last_f1;
        ch0 = 0; ch1 = 0; fr0 = 0; fr1 = 0; bad_rot = 0; bad_gap = 0; last_f1 = -1;
        @(negedge clk);
        prev0 = an_d[0];
        prev1 = an_d[1];
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (an_d[0] != prev0) begin
                ch0++;
                if (an_d[0] !== {prev0[6:0], prev0[7]}) bad_rot++;
            end
            if (an_d[1] != prev1) begin
                ch1++;
                if (an_d[1] !== {prev1[6:0], prev1[7]}) bad_rot++;
            end
            if (frame_d[0]) fr0++;
            if (frame_d[1]) begin
                fr1++;
                if (last_f1 >= 0 && c - last_f1 != 8) bad_gap++;
                last_f1 = c;
            end
            prev0 = an_d[0];
            prev1 = an_d[1];
        end
        vectors++;
        if (ch0 != 16) begin miscompares++; $display("FAIL scan_hold_div4 got %0d anode changes want 16", ch0); end
        vectors++;
        if (ch1 != 64) begin miscompares++; $display("FAIL scan_hold_div1 got %0d anode changes want 64", ch1); end
        vectors++;
        if (fr0 != 2) begin miscompares++; $display("FAIL frame_count_div4 got %0d want 2", fr0); end
        vectors++;
        if (fr1 != 8) begin miscompares++; $display("FAIL frame_count_div1 got %0d want 8", fr1); end
        vectors++;
        if (bad_rot != 0) begin miscompares++; $display("FAIL scan_order got %0d out-of-order steps want 0", bad_rot); end
        vectors++;
        if (bad_gap != 0) begin miscompares++; $display("FAIL frame_gap_div1 got %0d bad gaps want 0", bad_gap); end
    endtask

    task automatic test_no_tearing();
        int n;
        DataIn = 32'h0000000F;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_d[0] && n < 100);
        vectors++;
        if (!frame_d[0]) begin miscompares++; $display("FAIL tear_wait got no frame want frame within 100"); end
        for (int m = 1; m <= 32; m++) begin
            @(negedge clk);
            if (an_d[0] == 8'hFE) begin
                vectors++;
                if (seg_d[0] !== 7'h0E) begin
                    miscompares++;
                    $display("FAIL tear_digit0_old m=%0d got seg=%h want 0e", m, seg_d[0]);
                end
            end
            if (m == 12) DataIn = 32'h00000001;
        end
        vectors++;
        if (frame_d[0] !== 1'b1) begin miscompares++; $display("FAIL tear_frame got %b want 1", frame_d[0]); end
        @(negedge clk);
        vectors++;
        if (an_d[0] !== 8'hFE || seg_d[0] !== 7'h79) begin
            miscompares++;
            $display("FAIL tear_digit0_new got an=%h seg=%h want an=fe seg=79", an_d[0], seg_d[0]);
        end
    endtask

    task automatic test_blank_dp();
        int n, bad_dp;
        DataIn = $urandom | 32'h8000_0000;
        DpMask = 8'h01;
        Blank = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_d[0] && n < 100);
        repeat (2) @(negedge clk);
        Blank = 1'b1;
        @(negedge clk);
        vectors++;
        if (an_d[0] !== 8'hFF || an_d[1] !== 8'hFF) begin
            miscompares++;
            $display("FAIL blank_on got an=%h/%h want ff/ff", an_d[0], an_d[1]);
        end
        repeat (5) @(negedge clk);
        Blank = 1'b0;
        @(negedge clk);
        vectors++;
        if ($countones(~an_d[0]) != 1) begin
            miscompares++;
            $display("FAIL blank_release got an=%h want one active anode", an_d[0]);
        end
        bad_dp = 0;
        for (int m = 0; m < 32; m++) begin
            @(negedge clk);
            if (dp_d[0] !== (an_d[0] != 8'hFE)) bad_dp++;
        end
        vectors++;
        if (bad_dp != 0) begin miscompares++; $display("FAIL dp_digit0 got %0d wrong cycles want 0", bad_dp); end
        for (int m = 0; m < 96; m++) begin
            @(negedge clk);
            Blank  = ($urandom_range(0, 3) == 0);
            DpMask = 8'($urandom);
            DataIn = $urandom;
        end
        Blank = 1'b0;
    endtask

    task automatic test_lzb();
        int n;
        DataIn = 32'h0000000A;
        DpMask = 8'd0;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_d[0] && n < 100);
        for (int m = 1; m <= 32; m++) begin
            @(negedge clk);
            vectors++;
            if (m <= 4) begin
                if (an_d[0] !== 8'hFE || seg_d[0] !== 7'h08) begin
                    miscompares++;
                    $display("FAIL lzb_digit0 m=%0d got an=%h seg=%h want an=fe seg=08", m, an_d[0], seg_d[0]);
                end
            end else begin
`ifdef SEG7_LZB_EN
                if (an_d[0] !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL lzb_upper m=%0d got an=%h want ff", m, an_d[0]);
                end
`else
                if (an_d[0] == 8'hFF || seg_d[0] !== 7'h40) begin
                    miscompares++;
                    $display("FAIL lzb_upper m=%0d got an=%h seg=%h want driven anode seg=40", m, an_d[0], seg_d[0]);
                end
`endif
            end
        end
        DataIn = 32'd0;
        n = 0;
        do begin @(negedge clk); n++; end while (!frame_d[0] && n < 100);
        @(negedge clk);
        vectors++;
        if (an_d[0] !== 8'hFE || seg_d[0] !== 7'h40) begin
            miscompares++;
            $display("FAIL lzb_zero got an=%h seg=%h want an=fe seg=40", an_d[0], seg_d[0]);
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 200; m++) begin
            @(negedge clk);
            DataIn = $urandom >> $urandom_range(0, 31);
            DpMask = 8'($urandom);
            Blank  = ($urandom_range(0, 7) == 0);
        end
        Blank = 1'b0;
    endtask

    task automatic test_async_reset();
        DataIn = $urandom | 32'h8000_0000;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if ({an_d[j], seg_d[j], dp_d[j], frame_d[j]} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL async_reset dut%0d got an=%h seg=%h dp=%b frame=%b want an=ff seg=7f dp=1 frame=0",
                         j, an_d[j], seg_d[j], dp_d[j], frame_d[j]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if ({an_d[j], seg_d[j], frame_d[j]} !== {8'hFE, 7'h40, 1'b0}) begin
                miscompares++;
                $display("FAIL restart_digit0 dut%0d got an=%h seg=%h frame=%b want an=fe seg=40 frame=0",
                         j, an_d[j], seg_d[j], frame_d[j]);
            end
        end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_no_tearing();
        test_blank_dp();
        test_lzb();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
